faultify_cut_driver: RTL
========================

Name: faultify_cut_driver

Overview:
- Stimulus/injection master for the circuit-under-test wrapper: generates testVector and injectionVector, and collects resultVector.
- Drives one golden CUT (injection tied to zero) and one faulty CUT with identical test vectors for a programmed number of cycles.
- Compares the two results and counts mismatches and injection cycles.
- Sits between the AXI register block (config/status) and the two CUT instances.

Parameters:
- TEST_W, 64, testVector width
- RESULT_W, 23, resultVector width
- INJ_W, 13, injectionVector width (one bit per fault site)
- PROB_W, 16, injection-probability resolution
- CNT_W, 32, run-length and counter width
- CUT_LAT, 2, clock cycles from testVector to resultVector (>=0)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse that starts a run (honoured in IDLE/DONE only)
- cycles_i  in  CNT_W  number of stimulus cycles per run
- prob_i  in  PROB_W+1  per-site injection threshold; 2^PROB_W = always inject
- seed_i  in  64  LFSR seed
- test_vector_o  out  TEST_W  to both CUTs
- injection_vector_o  out  INJ_W  to faulty CUT
- result_golden_i  in  RESULT_W  golden CUT output
- result_faulty_i  in  RESULT_W  faulty CUT output
- busy_o  out  1  run in progress
- done_o  out  1  run complete; held until next accepted start
- err_cnt_o  out  CNT_W  compared cycles with any mismatch
- inj_cnt_o  out  CNT_W  issued cycles with injection_vector_o != 0

Behaviour:
- Reset (async, rst=0): all outputs 0, FSM in IDLE, LFSRs hold 1. Reset asserted mid-run aborts immediately; no partial status is retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start_i:
    - load test LFSR = seed_i (0 is replaced by 1)
    - load injection LFSR i = seed_i[15:0] ^ ((i+1)*16'h9E37) (0 is replaced by 1)
    - clear both counters and done_o
    - if cycles_i = 0, go to DONE the next cycle with counters 0; otherwise go to RUN with busy_o=1
  - RUN:
    - each cycle drive test_vector_o = test LFSR and advance it
    - injection bit i = (lfsr_i < prob_i), then advance lfsr_i
    - inj_cnt increments when any bit is set
    - after cycles_i issued cycles, go to DRAIN; vectors return to 0
  - DRAIN: wait CUT_LAT+1 cycles, then go to DONE.
  - DONE: busy_o=0, done_o=1.
- start_i during RUN/DRAIN is ignored.
- Comparison:
  - a valid shift register of depth CUT_LAT marks which result cycles belong to issued vectors
  - err_cnt increments when valid and result_golden_i != result_faulty_i
  - the compare is registered; err_cnt is final in DONE
- Test LFSR: 64-bit Fibonacci, taps 64,63,61,60, shift left, feedback into bit 0.
- Injection LFSRs: 16-bit Fibonacci, taps 16,14,13,11. With PROB_W != 16, use the low PROB_W bits.
- Counters saturate at all-ones; they never wrap.
- prob_i = 0: injection vector always 0. prob_i = 2^PROB_W: always all ones.
- Outputs test_vector_o and injection_vector_o are registered; the first vector appears on the cycle after leaving IDLE.

Optional Feature:
- Macro: FAULTIFY_FIRST_ERR_EN.
- Defined:
  - adds outputs first_err_cycle_o (CNT_W), first_err_diff_o (RESULT_W) and first_err_valid_o
  - captures the issue index (0-based) and golden^faulty of the first mismatch in a run
  - cleared on start
- Undefined: these ports and registers do not exist.

Decomposition:
- Package faultify_drv_pkg:
  - state enum
  - LFSR tap constants
  - seed-mixing constant 16'h9E37
  - lfsr16_next / lfsr64_next functions
- Sub-module faultify_inj_lfsr: one 16-bit LFSR, its comparator and seed load. Instantiated INJ_W times via generate.

Test Plan:
- Reset mid-RUN (cycles_i=100, rst low at issue 40) -> all outputs 0 next cycle, busy_o=0; a new start completes normally.
- cycles_i=10, prob_i=0, identical results -> 10 vectors matching the LFSR model from seed_i=64'h1; inj_cnt=0, err_cnt=0; done_o exactly 10+CUT_LAT+2 cycles after start.
- cycles_i=8, prob_i=65536 -> injection_vector_o=13'h1FFF on all 8 issue cycles; inj_cnt=8.
- Faulty result forced unequal on issue cycles 3 and 5 (CUT_LAT=2), cycles_i=10 -> err_cnt=2; with FAULTIFY_FIRST_ERR_EN, first_err_cycle_o=3.
- cycles_i=0 -> DONE one cycle after start, counters 0, no vectors issued; start_i pulsed during RUN -> ignored, run length unchanged.
- prob_i=32768, cycles_i=10000 -> per-site injection rate 0.5±0.02; counters do not wrap.

Source files
------------

// File: rtl/faultify_drv_pkg.sv
// faultify_drv_pkg: shared definitions for the CUT stimulus/injection driver.
//   - drv_state_e   : driver FSM states
//   - Lfsr64Taps    : test-vector LFSR tap mask (taps 64,63,61,60)
//   - Lfsr16Taps    : injection LFSR tap mask (taps 16,14,13,11)
//   - SeedMix       : per-site seed decorrelation constant
//   - lfsr64_next / lfsr16_next : Fibonacci shift-left, feedback into bit 0
package faultify_drv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } drv_state_e;

  localparam logic [63:0] Lfsr64Taps = 64'hD800_0000_0000_0000;
  localparam logic [15:0] Lfsr16Taps = 16'hB400;
  localparam logic [15:0] SeedMix    = 16'h9E37;

  function automatic logic [63:0] lfsr64_next(input logic [63:0] s);
    return {s[62:0], ^(s & Lfsr64Taps)};
  endfunction

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], ^(s & Lfsr16Taps)};
  endfunction

endpackage

// File: rtl/faultify_inj_lfsr.sv
// faultify_inj_lfsr: one fault-site injection source.
// A 16-bit Fibonacci LFSR whose low PROB_W bits are compared against the
// injection threshold; the site fires when the LFSR value is below it.
// Ports:
//   clk, rst : clock, asynchronous active-low reset (LFSR resets to 1)
//   load     : load the site-mixed seed
//   step     : advance the LFSR by one state
//   seed     : shared 16-bit seed (mixed with this site's index)
//   prob     : threshold, PROB_W+1 bits; 2^PROB_W fires every cycle
//   hit      : combinational injection bit for the current LFSR state
// Assumes PROB_W <= 16.
module faultify_inj_lfsr
  import faultify_drv_pkg::*;
#(
  parameter int unsigned PROB_W = 16,
  parameter int unsigned SITE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [15:0]       seed,
  input  logic [PROB_W:0]   prob,
  output logic              hit
);

  localparam logic [31:0] SiteMixWide = (SITE + 32'd1) * {16'd0, SeedMix};
  localparam logic [15:0] SiteMix     = SiteMixWide[15:0];

  logic [15:0] lfsr_q;
  logic [15:0] seed_mix;

  always_comb begin
    seed_mix = seed ^ SiteMix;
    hit      = {1'b0, lfsr_q[PROB_W-1:0]} < prob;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 16'd1;
    end else if (load) begin
      // an all-zero LFSR would lock up
      lfsr_q <= (seed_mix == 16'd0) ? 16'd1 : seed_mix;
    end else if (step) begin
      lfsr_q <= lfsr16_next(lfsr_q);
    end
  end

endmodule

// File: rtl/faultify_cut_driver.sv
// faultify_cut_driver: stimulus/injection master for a golden/faulty CUT pair.
// Issues cycles_i pseudo-random test vectors (64-bit LFSR) to both CUTs and a
// per-site injection vector to the faulty CUT, then counts result mismatches
// and injecting cycles.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start_i             : start pulse, honoured in IDLE/DONE only
//   cycles_i            : vectors per run (0 finishes immediately)
//   prob_i              : injection threshold per site
//   seed_i              : LFSR seed
//   test_vector_o       : registered test vector to both CUTs
//   injection_vector_o  : registered injection vector to the faulty CUT
//   result_golden_i     : golden CUT result
//   result_faulty_i     : faulty CUT result
//   busy_o / done_o     : run status; done_o holds until the next start
//   err_cnt_o           : compared cycles with a mismatch (saturating)
//   inj_cnt_o           : issued cycles with a nonzero injection vector (saturating)
// Optional (FAULTIFY_FIRST_ERR_EN): first_err_cycle_o, first_err_diff_o,
//   first_err_valid_o report the issue index and golden^faulty of the first mismatch.
// Assumes TEST_W <= 64.
module faultify_cut_driver
  import faultify_drv_pkg::*;
#(
  parameter int unsigned TEST_W   = 64,
  parameter int unsigned RESULT_W = 23,
  parameter int unsigned INJ_W    = 13,
  parameter int unsigned PROB_W   = 16,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned CUT_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    cycles_i,
  input  logic [PROB_W:0]     prob_i,
  input  logic [63:0]         seed_i,
  output logic [TEST_W-1:0]   test_vector_o,
  output logic [INJ_W-1:0]    injection_vector_o,
  input  logic [RESULT_W-1:0] result_golden_i,
  input  logic [RESULT_W-1:0] result_faulty_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic [CNT_W-1:0]    inj_cnt_o
`ifdef FAULTIFY_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0]    first_err_cycle_o,
  output logic [RESULT_W-1:0] first_err_diff_o,
  output logic                first_err_valid_o
`endif
);

  localparam int unsigned DrainW = $clog2(CUT_LAT + 1) + 1;

  drv_state_e          state_q;
  logic [63:0]         test_lfsr_q;
  logic [CNT_W-1:0]    issued_q;
  logic [CNT_W-1:0]    cycles_q;
  logic [DrainW-1:0]   drain_q;
  // valid_q[0] tags the vector currently on test_vector_o; the tail lines up
  // with the result that vector produces CUT_LAT cycles later.
  logic [CUT_LAT:0]    valid_q;

  logic                load;
  logic                issue;
  logic                cmp_valid;
  logic                mismatch;
  logic [INJ_W-1:0]    inj_hit;

  always_comb begin
    load      = start_i && ((state_q == StIdle) || (state_q == StDone));
    issue     = (state_q == StRun);
    cmp_valid = valid_q[CUT_LAT];
    mismatch  = cmp_valid && (result_golden_i != result_faulty_i);
  end

  for (genvar g = 0; g < INJ_W; g++) begin : gen_site
    faultify_inj_lfsr #(
      .PROB_W (PROB_W),
      .SITE   (g)
    ) u_site (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (issue),
      .seed (seed_i[15:0]),
      .prob (prob_i),
      .hit  (inj_hit[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= StIdle;
      test_lfsr_q        <= 64'd1;
      issued_q           <= '0;
      cycles_q           <= '0;
      drain_q            <= '0;
      valid_q            <= '0;
      test_vector_o      <= '0;
      injection_vector_o <= '0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      err_cnt_o          <= '0;
      inj_cnt_o          <= '0;
    end else begin
      valid_q[0] <= issue;
      for (int unsigned i = 1; i <= CUT_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
      end

      if (mismatch && (err_cnt_o != '1)) begin
        err_cnt_o <= err_cnt_o + CNT_W'(1);
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            test_lfsr_q <= (seed_i == 64'd0) ? 64'd1 : seed_i;
            issued_q    <= '0;
            cycles_q    <= cycles_i;
            err_cnt_o   <= '0;
            inj_cnt_o   <= '0;
            if (cycles_i == '0) begin
              state_q <= StDone;
              done_o  <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_o  <= 1'b1;
              done_o  <= 1'b0;
            end
          end
        end
        StRun: begin
          test_vector_o      <= TEST_W'(test_lfsr_q);
          test_lfsr_q        <= lfsr64_next(test_lfsr_q);
          injection_vector_o <= inj_hit;
          if ((inj_hit != '0) && (inj_cnt_o != '1)) begin
            inj_cnt_o <= inj_cnt_o + CNT_W'(1);
          end
          issued_q <= issued_q + CNT_W'(1);
          if (issued_q == cycles_q - CNT_W'(1)) begin
            state_q <= StDrain;
            drain_q <= '0;
          end
        end
        StDrain: begin
          test_vector_o      <= '0;
          injection_vector_o <= '0;
          // CUT_LAT+1 cycles lets the last result reach the registered compare
          if (drain_q == DrainW'(CUT_LAT)) begin
            state_q <= StDone;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            drain_q <= drain_q + DrainW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FAULTIFY_FIRST_ERR_EN
  // Compares retire in issue order, so the compare count is the issue index.
  logic [CNT_W-1:0] cmp_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_idx_q         <= '0;
      first_err_cycle_o <= '0;
      first_err_diff_o  <= '0;
      first_err_valid_o <= 1'b0;
    end else if (load) begin
      cmp_idx_q         <= '0;
      first_err_cycle_o <= '0;
      first_err_diff_o  <= '0;
      first_err_valid_o <= 1'b0;
    end else if (cmp_valid) begin
      if (mismatch && !first_err_valid_o) begin
        first_err_valid_o <= 1'b1;
        first_err_cycle_o <= cmp_idx_q;
        first_err_diff_o  <= result_golden_i ^ result_faulty_i;
      end
      if (cmp_idx_q != '1) begin
        cmp_idx_q <= cmp_idx_q + CNT_W'(1);
      end
    end
  end
`endif

endmodule
